// File: rtl/vga_attrfill.sv
`default_nettype none
// ============================================================================
// Module      : vga_attrfill
// Description : Rectangle fill engine for the character attribute RAM. Clips
//               a cell rectangle to the screen and writes one attribute byte
//               to every covered cell, one cell per clock, in raster order.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_attrfill #(
  parameter int cols       = 80,
  parameter int rows       = 30,
  parameter int addr_width = 12,
  parameter int bit_width  = 8,
  parameter int col_width  = 7,
  parameter int row_width  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [col_width-1:0]  x0,
  input  logic [row_width-1:0]  y0,
  input  logic [col_width-1:0]  w,
  input  logic [row_width-1:0]  h,
  input  logic [bit_width-1:0]  attr,
  output logic                  busy,
  output logic                  done,
  output logic [addr_width-1:0] addr_a,
  output logic                  wr_en_a,
  output logic [bit_width-1:0]  data_wr_a
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [col_width-1:0]  cols_c = col_width'(cols);
  localparam logic [row_width-1:0]  rows_c = row_width'(rows);
  localparam logic [addr_width-1:0] cols_a = addr_width'(cols);

  state_t state, state_next;

  // Request parameters captured when a fill is accepted
  logic [col_width-1:0]  x0_q;
  logic [row_width-1:0]  y0_q;
  logic [col_width-1:0]  w_q;
  logic [row_width-1:0]  h_q;
  logic [bit_width-1:0]  attr_q;

  // Walk state: current column, last column of a row, start of current row
  logic [col_width-1:0]  col;
  logic [col_width-1:0]  col_end;
  logic [addr_width-1:0] row_base;
  logic [row_width-1:0]  rows_left;

  logic [col_width-1:0]  cw_c;
  logic [row_width-1:0]  ch_c;
  logic [addr_width-1:0] base_c;
  logic                  last_col;
  logic                  last_cell;

  // Clip the latched rectangle against the screen edges
  always_comb begin
    cw_c = '0;
    ch_c = '0;
    if (x0_q < cols_c) begin
      cw_c = (w_q < (cols_c - x0_q)) ? w_q : (cols_c - x0_q);
    end
    if (y0_q < rows_c) begin
      ch_c = (h_q < (rows_c - y0_q)) ? h_q : (rows_c - y0_q);
    end
    base_c    = addr_width'(y0_q) * cols_a;
    last_col  = (col == col_end);
    last_cell = last_col && (rows_left == row_width'(1));
  end

  // State register; reset parks the engine in IDLE at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state decode; abort only matters while a fill is being set up or run
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_SETUP;
      ST_SETUP: begin
        if (abort)                             state_next = ST_IDLE;
        else if ((cw_c == '0) || (ch_c == '0)) state_next = ST_DONE;
        else                                   state_next = ST_FILL;
      end
      ST_FILL: begin
        if (abort)          state_next = ST_IDLE;
        else if (last_cell) state_next = ST_DONE;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Registered outputs follow the next state so the RAM port is glitch-free;
  // the address is precomputed one cycle ahead of the cell it describes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_en_a   <= 1'b0;
      addr_a    <= '0;
      data_wr_a <= '0;
      x0_q      <= '0;
      y0_q      <= '0;
      w_q       <= '0;
      h_q       <= '0;
      attr_q    <= '0;
      col       <= '0;
      col_end   <= '0;
      row_base  <= '0;
      rows_left <= '0;
    end else begin
      busy    <= (state_next == ST_SETUP) || (state_next == ST_FILL);
      done    <= (state_next == ST_DONE);
      wr_en_a <= (state_next == ST_FILL);
      case (state)
        ST_IDLE: begin
          if (start) begin
            x0_q   <= x0;
            y0_q   <= y0;
            w_q    <= w;
            h_q    <= h;
            attr_q <= attr;
          end
        end
        ST_SETUP: begin
          col       <= x0_q;
          col_end   <= x0_q + cw_c - col_width'(1);
          row_base  <= base_c;
          rows_left <= ch_c;
          addr_a    <= base_c + addr_width'(x0_q);
          data_wr_a <= attr_q;
        end
        ST_FILL: begin
          if (last_col) begin
            col       <= x0_q;
            row_base  <= row_base + cols_a;
            rows_left <= rows_left - row_width'(1);
            addr_a    <= row_base + cols_a + addr_width'(x0_q);
          end else begin
            col    <= col + col_width'(1);
            addr_a <= addr_a + addr_width'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_attrfill.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_attrfill
// Description : Self-checking bench for vga_attrfill. Directed and random
//               rectangles are compared cycle by cycle against a reference
//               timeline built from clipped cell lists.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_attrfill;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [6:0]  x0 = '0;
  logic [4:0]  y0 = '0;
  logic [6:0]  w = '0;
  logic [4:0]  h = '0;
  logic [7:0]  attr = '0;
  logic        busy;
  logic        done;
  logic [11:0] addr_a;
  logic        wr_en_a;
  logic [7:0]  data_wr_a;

  int checks = 0;
  int failures = 0;

  vga_attrfill dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .x0        (x0),
    .y0        (y0),
    .w         (w),
    .h         (h),
    .attr      (attr),
    .busy      (busy),
    .done      (done),
    .addr_a    (addr_a),
    .wr_en_a   (wr_en_a),
    .data_wr_a (data_wr_a)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    x0   = 7'($urandom);
    y0   = 5'($urandom);
    w    = 7'($urandom);
    h    = 5'($urandom);
    attr = 8'($urandom);
  endtask

  // Call just after a rising edge with the engine idle.
  // abort_cyc: cycle (relative to the accepting edge) in which abort is held,
  //            0 = never. mid_cyc: cycle in which a stray start is pulsed.
  task automatic run_fill(input int xv, input int yv, input int wv, input int hv,
                          input int av, input int abort_cyc, input int mid_cyc,
                          input bit abort_with_start);
    int cw, ch, n, last;
    int cells[$];
    bit live, eb, ew, ed;
    cw = (xv >= 80) ? 0 : ((wv < 80 - xv) ? wv : 80 - xv);
    ch = (yv >= 30) ? 0 : ((hv < 30 - yv) ? hv : 30 - yv);
    for (int r = 0; r < ch; r++)
      for (int c = 0; c < cw; c++)
        cells.push_back((yv + r) * 80 + xv + c);
    n = cw * ch;
    last = (abort_cyc > 0) ? abort_cyc + 2 : n + 3;
    x0 = 7'(xv); y0 = 5'(yv); w = 7'(wv); h = 5'(hv); attr = 8'(av);
    start = 1'b1;
    abort = abort_with_start;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    scramble();
    for (int k = 1; k <= last; k++) begin
      abort = (k == abort_cyc);
      if (k == mid_cyc) begin
        start = 1'b1;
        scramble();
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      live = (abort_cyc == 0) || (k <= abort_cyc);
      eb = live && (k <= n + 1);
      ew = live && (k >= 2) && (k <= n + 1);
      ed = (abort_cyc == 0) && (k == n + 2);
      chk("busy", 32'(busy), 32'(eb));
      chk("wr_en_a", 32'(wr_en_a), 32'(ew));
      chk("done", 32'(done), 32'(ed));
      if (ew) begin
        chk("addr_a", 32'(addr_a), 32'(cells[k-2]));
        chk("data_wr_a", 32'(data_wr_a), 32'(av & 8'hFF));
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int xv, yv, wv, hv, cwv, chv, nv, ab, md;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wr_en", 32'(wr_en_a), 0);
    chk("rst_addr", 32'(addr_a), 0);
    chk("rst_data", 32'(data_wr_a), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full screen, done in cycle 2402
    run_fill(0, 0, 80, 30, 8'h5A, 0, 0, 1'b0);
    // Interior rectangle
    run_fill(10, 2, 3, 2, 8'h83, 0, 0, 1'b0);
    // Clipping at bottom-right corner, and fully off the right edge
    run_fill(78, 29, 5, 4, 8'h11, 0, 0, 1'b0);
    run_fill(80, 0, 5, 1, 8'h22, 0, 0, 1'b0);
    // Zero width
    run_fill(5, 5, 0, 3, 8'h33, 0, 0, 1'b0);
    // Off the bottom edge
    run_fill(0, 31, 4, 4, 8'h44, 0, 0, 1'b0);
    // Stray start mid-fill and in the DONE cycle
    run_fill(10, 2, 3, 2, 8'h83, 0, 4, 1'b0);
    run_fill(10, 2, 3, 2, 8'h84, 0, 8, 1'b0);
    // Abort during the 5th write of a full-screen fill
    run_fill(0, 0, 80, 30, 8'h5A, 6, 0, 1'b0);
    // Abort in SETUP
    run_fill(3, 3, 4, 4, 8'h66, 1, 0, 1'b0);
    // start and abort together in IDLE: start wins
    run_fill(20, 10, 7, 3, 8'h77, 0, 0, 1'b1);

    // Random rectangles with occasional aborts and stray starts
    for (int i = 0; i < 40; i++) begin
      xv = $urandom_range(0, 100);
      yv = $urandom_range(0, 31);
      wv = $urandom_range(0, 24);
      hv = $urandom_range(0, 8);
      cwv = (xv >= 80) ? 0 : ((wv < 80 - xv) ? wv : 80 - xv);
      chv = (yv >= 30) ? 0 : ((hv < 30 - yv) ? hv : 30 - yv);
      nv = cwv * chv;
      ab = (($urandom % 4) == 0) ? $urandom_range(1, nv + 1) : 0;
      md = (($urandom % 3) == 0) ? $urandom_range(1, (ab > 0) ? ab : nv + 2) : 0;
      run_fill(xv, yv, wv, hv, $urandom_range(0, 255), ab, md, 1'($urandom));
    end

    // Reset in the middle of a fill
    x0 = 7'd0; y0 = 5'd0; w = 7'd80; h = 5'd30; attr = 8'hC3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("pre_rst_wr_en", 32'(wr_en_a), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", 32'(wr_en_a), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_addr", 32'(addr_a), 0);
    chk("mid_rst_done", 32'(done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_fill(40, 20, 6, 3, 8'h9E, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
